// File: rtl/rand_txn_scheduler_if.sv
// Purpose: AHB5 transaction descriptor link from the scheduler to the AHB master driver.
// Latency: none; this is wiring only.
// Backpressure: the driver holds txn_ready low, and the descriptor stays on the bus until it accepts.
interface rand_txn_scheduler_if #(
  parameter int ADDR_W = 32
);
  logic              txn_valid;
  logic              txn_ready;
  logic [ADDR_W-1:0] txn_addr;
  logic              txn_write;
  logic [2:0]        txn_size;
  logic [2:0]        txn_burst;

  modport master (
    output txn_valid, txn_addr, txn_write, txn_size, txn_burst,
    input  txn_ready
  );

  modport slave (
    input  txn_valid, txn_addr, txn_write, txn_size, txn_burst,
    output txn_ready
  );
endinterface

// File: rtl/rand_txn_scheduler.sv
// Purpose: turns the free-running LFSR word into legal AHB5 descriptors, separated by random idle gaps.
// Latency: start at edge 0 gives CTRL in cycle 1, ADDR in cycle 2 and txn_valid in cycle 3; with no gap, one descriptor every 3 cycles.
// Backpressure: an offer holds, with all fields frozen, until txn_ready; stop is remembered and applied at the handshake.
module rand_txn_scheduler #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter int GAP_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          i_rand_val,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [CNT_W-1:0]     i_num_txn,
  input  logic [ADDR_W-1:0]    i_addr_base,
  input  logic [ADDR_W-1:0]    i_addr_mask,
  input  logic [GAP_W-1:0]     i_gap_mask,
  rand_txn_scheduler_if.master o_txn,
  output logic [CNT_W-1:0]     o_txn_count,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CTRL,
    S_ADDR,
    S_OFFER,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [2:0]          r_size;
  logic [2:0]          r_burst;
  logic [GAP_W-1:0]    r_gap;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_num_txn;
  logic                r_stop_pending;

  logic                w_busy;
  logic                w_hs;
  logic                w_stop_now;
  logic                w_last;
  logic [ADDR_W-1:0]   w_addr_raw;
  logic [ADDR_W-1:0]   w_addr_aligned;
  logic [10:0]         w_beats;
  logic [10:0]         w_bytes;
  logic [10:0]         w_span;
  logic                w_cross;
  logic [2:0]          w_size_sel;

  assign w_busy     = (r_state == S_CTRL) || (r_state == S_ADDR) ||
                      (r_state == S_OFFER) || (r_state == S_GAP);
  assign w_hs       = (r_state == S_OFFER) && o_txn.txn_ready;
  assign w_stop_now = i_stop || r_stop_pending;
  // A limit of zero means "unlimited", so it never ends the run.
  assign w_last     = (r_num_txn != '0) && ((r_count + CNT_ONE) == r_num_txn);

  // HSIZE is capped at a word: code 3 from the random word maps down to 2.
  assign w_size_sel = (i_rand_val[2:1] == 2'b11) ? 3'd2 : {1'b0, i_rand_val[2:1]};

  assign w_addr_raw = (i_addr_base & ~i_addr_mask) | (i_rand_val & i_addr_mask);

  // Align the address to the latched transfer size.
  always_comb begin
    w_addr_aligned = w_addr_raw;
    if (r_size == 3'd1) begin
      w_addr_aligned[0] = 1'b0;
    end else if (r_size == 3'd2) begin
      w_addr_aligned[1:0] = 2'b00;
    end
  end

  // Beat count for the fixed-length incrementing bursts; every other burst type is exempt from the 1KB check.
  always_comb begin
    w_beats = 11'd0;
    unique case (r_burst)
      3'd3:    w_beats = 11'd4;
      3'd5:    w_beats = 11'd8;
      3'd7:    w_beats = 11'd16;
      default: w_beats = 11'd0;
    endcase
  end

  assign w_bytes = w_beats << r_size;
  assign w_span  = {1'b0, w_addr_aligned[9:0]} + w_bytes;
  assign w_cross = (w_span > 11'd1024);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; a stop seen in CTRL, ADDR or GAP ends the run immediately.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next_state = S_CTRL;
      S_CTRL:  w_next_state = w_stop_now ? S_DONE : S_ADDR;
      S_ADDR:  w_next_state = w_stop_now ? S_DONE : S_OFFER;
      S_OFFER: begin
        if (w_hs) begin
          if (w_last || w_stop_now) begin
            w_next_state = S_DONE;
          end else if (r_gap == '0) begin
            w_next_state = S_CTRL;
          end else begin
            w_next_state = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (w_stop_now) begin
          w_next_state = S_DONE;
        end else if (r_gap == GAP_ONE) begin
          w_next_state = S_CTRL;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Run bookkeeping, descriptor capture and the gap countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr         <= '0;
      r_write        <= 1'b0;
      r_size         <= 3'd0;
      r_burst        <= 3'd0;
      r_gap          <= '0;
      r_count        <= '0;
      r_num_txn      <= '0;
      r_stop_pending <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && i_start) begin
        r_count        <= '0;
        r_num_txn      <= i_num_txn;
        r_stop_pending <= 1'b0;
      end else if (w_busy && i_stop) begin
        r_stop_pending <= 1'b1;
      end

      if ((r_state == S_CTRL) && !w_stop_now) begin
        r_write <= i_rand_val[0];
        r_size  <= w_size_sel;
        r_burst <= i_rand_val[5:3];
        r_gap   <= i_rand_val[6 +: GAP_W] & i_gap_mask;
      end

      // A burst that would cross a 1KB boundary is demoted to SINGLE.
      if ((r_state == S_ADDR) && !w_stop_now) begin
        r_addr <= w_addr_aligned;
        if (w_cross) begin
          r_burst <= 3'd0;
        end
      end

      if (w_hs) begin
        r_count <= r_count + CNT_ONE;
      end

      if (r_state == S_GAP) begin
        r_gap <= r_gap - GAP_ONE;
      end
    end
  end

  assign o_txn.txn_valid = (r_state == S_OFFER);
  assign o_txn.txn_addr  = r_addr;
  assign o_txn.txn_write = r_write;
  assign o_txn.txn_size  = r_size;
  assign o_txn.txn_burst = r_burst;
  assign o_txn_count     = r_count;
  assign o_busy          = w_busy;
  assign o_done          = (r_state == S_DONE);

endmodule
